// File: rtl/vgg16_pkg.sv
// Constants and types shared by the VGG16 layer engines that sit on the common BRAM.
package vgg16_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned READ_LAT = 2;
  localparam int unsigned PHASE_W  = $clog2(READ_LAT + 1);

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StCheck = 5'b00010,
    StRead  = 5'b00100,
    StWrite = 5'b01000,
    StDone  = 5'b10000
  } layer_state_e;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/maxpool_flatten_if.sv
// Single-port BRAM bus shared by the VGG16 layer engines; one master at a time.
interface maxpool_flatten_if;
  import vgg16_pkg::*;

  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (output ena, wea, addra, dina, input douta);
  modport slave  (input ena, wea, addra, dina, output douta);

endinterface

// File: rtl/pool_addr_gen.sv
// Loop counters (c, orow, ocol, window index k) and input/output address generation.
module pool_addr_gen
  import vgg16_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              k_clr_i,
  input  logic              k_inc_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] in_base_i,
  input  logic [ADDR_W-1:0] out_base_i,
  input  logic [7:0]        h_i,
  input  logic [7:0]        w_i,
  input  logic [9:0]        c_num_i,
  output logic [ADDR_W-1:0] in_addr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              k_first_o,
  output logic              k_last_o,
  output logic              c_done_o,
  output logic              empty_o
);

  logic [9:0] c_q, c_d;
  logic [6:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [1:0] k_q, k_d;
  logic [6:0] ho, wo;
  logic [7:0] row, col;

  assign ho  = h_i[7:1];
  assign wo  = w_i[7:1];
  assign row = {orow_q, k_q[1]};
  assign col = {ocol_q, k_q[0]};

  always_comb begin
    c_d    = c_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    k_d    = k_q;
    if (clr_i) begin
      c_d    = '0;
      orow_d = '0;
      ocol_d = '0;
      k_d    = '0;
    end else begin
      if (k_clr_i) k_d = '0;
      if (k_inc_i) k_d = k_q + 2'd1;
      if (adv_i) begin
        if (ocol_q == wo - 7'd1) begin
          ocol_d = '0;
          if (orow_q == ho - 7'd1) begin
            orow_d = '0;
            c_d    = c_q + 10'd1;
          end else begin
            orow_d = orow_q + 7'd1;
          end
        end else begin
          ocol_d = ocol_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q    <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      k_q    <= '0;
    end else begin
      c_q    <= c_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      k_q    <= k_d;
    end
  end

  // All products are taken at ADDR_W bits so oversized maps wrap rather than widen.
  assign in_addr_o  = in_base_i + ADDR_W'(c_q) * ADDR_W'(h_i) * ADDR_W'(w_i)
                    + ADDR_W'(row) * ADDR_W'(w_i) + ADDR_W'(col);
  assign out_addr_o = out_base_i + ADDR_W'(c_q) * ADDR_W'(ho) * ADDR_W'(wo)
                    + ADDR_W'(orow_q) * ADDR_W'(wo) + ADDR_W'(ocol_q);

  assign k_first_o = (k_q == 2'd0);
  assign k_last_o  = (k_q == 2'd3);
  assign c_done_o  = (c_q == c_num_i);
  assign empty_o   = (ho == '0) || (wo == '0) || (c_num_i == '0);

endmodule

// File: rtl/maxpool_flatten.sv
// 2x2/stride-2 max pooling from the shared BRAM into a flattened vector for the FC stage.
// Build option: define POOL_RELU_EN to clamp negative pooled results to zero on write.
module maxpool_flatten
  import vgg16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pool_en,
  input  logic [ADDR_W-1:0]   in_base_addr,
  input  logic [ADDR_W-1:0]   out_base_addr,
  input  logic [7:0]          height,
  input  logic [7:0]          width,
  input  logic [9:0]          channels,
  maxpool_flatten_if.master   vgg16_bram,
  output logic                pool_finish
);

  layer_state_e       state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0]  max_q, max_d, wr_val;
  logic [7:0]         h_q, h_d, w_q, w_d;
  logic [9:0]         c_num_q, c_num_d;
  logic [ADDR_W-1:0]  in_base_q, in_base_d, out_base_q, out_base_d;
  logic [ADDR_W-1:0]  in_addr, out_addr;
  logic               k_first, k_last, c_done, empty, rd_done, wr_end;

  assign rd_done = (state_q == StRead) && (phase_q == PHASE_W'(READ_LAT));
  assign wr_end  = (state_q == StWrite) && (phase_q != '0);

  pool_addr_gen u_addr_gen (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (pool_en && (state_q == StIdle)),
    .k_clr_i    (pool_en && (state_q == StCheck)),
    .k_inc_i    (pool_en && rd_done),
    .adv_i      (pool_en && wr_end),
    .in_base_i  (in_base_q),
    .out_base_i (out_base_q),
    .h_i        (h_q),
    .w_i        (w_q),
    .c_num_i    (c_num_q),
    .in_addr_o  (in_addr),
    .out_addr_o (out_addr),
    .k_first_o  (k_first),
    .k_last_o   (k_last),
    .c_done_o   (c_done),
    .empty_o    (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Releasing pool_en is the only way out of StDone; elsewhere it freezes the block.
  always_comb begin
    state_d = state_q;
    if (!pool_en) begin
      if (state_q == StDone) state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StCheck;
        StCheck: state_d = (empty || c_done) ? StDone : StRead;
        StRead:  if (rd_done && k_last) state_d = StWrite;
        StWrite: if (wr_end) state_d = StCheck;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    phase_d    = phase_q;
    max_d      = max_q;
    h_d        = h_q;
    w_d        = w_q;
    c_num_d    = c_num_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    unique case (state_q)
      StIdle: begin
        h_d        = height;
        w_d        = width;
        c_num_d    = channels;
        in_base_d  = in_base_addr;
        out_base_d = out_base_addr;
        phase_d    = '0;
        max_d      = '0;
      end
      StCheck: phase_d = '0;
      StRead: begin
        if (rd_done) begin
          phase_d = '0;
          if (k_first || ($signed(vgg16_bram.douta) > $signed(max_q))) max_d = vgg16_bram.douta;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      StWrite: phase_d = wr_end ? '0 : PHASE_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= '0;
      max_q      <= '0;
      h_q        <= '0;
      w_q        <= '0;
      c_num_q    <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
    end else if (pool_en) begin
      phase_q    <= phase_d;
      max_q      <= max_d;
      h_q        <= h_d;
      w_q        <= w_d;
      c_num_q    <= c_num_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
    end
  end

`ifdef POOL_RELU_EN
  assign wr_val = relu(max_q);
`else
  assign wr_val = max_q;
`endif

  always_comb begin
    vgg16_bram.ena   = ((state_q == StRead) || (state_q == StWrite)) && (phase_q == '0);
    vgg16_bram.wea   = (state_q == StWrite) && (phase_q == '0);
    vgg16_bram.addra = '0;
    vgg16_bram.dina  = '0;
    if (vgg16_bram.wea) begin
      vgg16_bram.addra = out_addr;
      vgg16_bram.dina  = wr_val;
    end else if (vgg16_bram.ena) begin
      vgg16_bram.addra = in_addr;
    end
    pool_finish = (state_q == StDone);
  end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Directed bench for maxpool_flatten against a READ_LAT=2 BRAM model.
module tb_maxpool_flatten;
  import vgg16_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              pool_en = 1'b0;
  logic [ADDR_W-1:0] in_base_addr = '0, out_base_addr = '0;
  logic [7:0]        height = '0, width = '0;
  logic [9:0]        channels = '0;
  logic              pool_finish;

  maxpool_flatten_if bram ();

  maxpool_flatten dut (
    .clk           (clk),
    .rst           (rst),
    .pool_en       (pool_en),
    .in_base_addr  (in_base_addr),
    .out_base_addr (out_base_addr),
    .height        (height),
    .width         (width),
    .channels      (channels),
    .vgg16_bram    (bram),
    .pool_finish   (pool_finish)
  );

  always #5 clk = ~clk;

  // BRAM model: address registered on edge N, douta valid for sampling on edge N+2.
  logic [7:0]  mem [0:4095];
  logic [11:0] raddr_q = '0;
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  logic [ADDR_W-1:0] wr_addr [$];
  logic [7:0]        wr_data [$];
  int rd_hits [0:4095];
  int en_cnt = 0;
  int bad_wea = 0;

  initial for (int i = 0; i < 4096; i++) rd_hits[i] = 0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bram.ena) begin
      if (bram.wea) mem[bram.addra[11:0]] <= bram.dina;
      else raddr_q <= bram.addra[11:0];
    end
    bram.douta <= mem[raddr_q];
    if (bram.wea && !bram.ena) bad_wea++;
    if (bram.ena) en_cnt++;
    if (bram.ena && bram.wea) begin
      wr_addr.push_back(bram.addra);
      wr_data.push_back(bram.dina);
    end
    if (bram.ena && !bram.wea) rd_hits[bram.addra[11:0]]++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic longint wa(input int i);
    return (i < wr_addr.size()) ? longint'(wr_addr[i]) : -1;
  endfunction

  function automatic longint wd(input int i);
    return (i < wr_data.size()) ? longint'(wr_data[i]) : -1;
  endfunction

  function automatic logic [7:0] wexp(input logic [7:0] m);
`ifdef POOL_RELU_EN
    return m[7] ? 8'h00 : m;
`else
    return m;
`endif
  endfunction

  // Called on a negedge; returns on the following negedge.
  task automatic poke(input int a, input logic [7:0] d);
    pl_we = 1'b1;
    pl_addr = 12'(a);
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic run(input int h, input int w, input int c, input int ib, input int ob,
                     input int freeze_at, output int cyc);
    height = 8'(h);
    width = 8'(w);
    channels = 10'(c);
    in_base_addr = ADDR_W'(ib);
    out_base_addr = ADDR_W'(ob);
    @(negedge clk);
    pool_en = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == freeze_at) begin
        logic              en_s;
        logic [ADDR_W-1:0] a_s;
        en_s = bram.ena;
        a_s = bram.addra;
        pool_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          cyc++;
          chk("freeze_ena", bram.ena, en_s);
          chk("freeze_addra", bram.addra, a_s);
        end
        pool_en = 1'b1;
      end
      if (pool_finish) break;
      if (cyc > 5000) begin
        chk("run_timeout", 0, 1);
        break;
      end
    end
    pool_en = 1'b0;
    @(negedge clk);
    chk("finish_clears", pool_finish, 0);
  endtask

  typedef struct {
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] mx;
  } vec_t;

  vec_t tbl [7];
  int exp44 [8];

  initial begin
    int cyc, wb, eb, sum_bad, sum_all;
    tbl[0] = '{8'h03, 8'hF9, 8'h09, 8'h01, 8'h09};
    tbl[1] = '{8'hFB, 8'hFE, 8'hF7, 8'hFD, 8'hFE};
    tbl[2] = '{8'h7F, 8'h80, 8'h00, 8'h05, 8'h7F};
    tbl[3] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    tbl[5] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};
    tbl[6] = '{8'h0A, 8'h02, 8'hFF, 8'h0A, 8'h0A};
    exp44 = '{5, 7, 13, 15, 21, 23, 29, 31};

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_ena", bram.ena, 0);
    chk("rst_wea", bram.wea, 0);
    chk("rst_addra", bram.addra, 0);
    chk("rst_dina", bram.dina, 0);
    chk("rst_finish", pool_finish, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single 2x2 windows.
    for (int t = 0; t < 7; t++) begin
      poke(12'h100, tbl[t].a0);
      poke(12'h101, tbl[t].a1);
      poke(12'h102, tbl[t].a2);
      poke(12'h103, tbl[t].a3);
      wb = wr_addr.size();
      run(2, 2, 1, 'h100, 'h200, 0, cyc);
      chk($sformatf("v%0d_latency", t), cyc, 17);
      chk($sformatf("v%0d_nwrites", t), wr_addr.size() - wb, 1);
      chk($sformatf("v%0d_addr", t), wa(wb), 'h200);
      chk($sformatf("v%0d_data", t), wd(wb), wexp(tbl[t].mx));
    end

    // 4x4x2 map, value = index: each output is its window's bottom-right element.
    for (int i = 0; i < 32; i++) poke(i, 8'(i));
    for (int f = 0; f < 2; f++) begin
      wb = wr_addr.size();
      run(4, 4, 2, 'h000, 'h300, (f == 1) ? 20 : 0, cyc);
      chk($sformatf("m44_f%0d_latency", f), cyc, (f == 1) ? 127 : 122);
      chk($sformatf("m44_f%0d_nwrites", f), wr_addr.size() - wb, 8);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("m44_f%0d_addr%0d", f, i), wa(wb + i), 'h300 + i);
        chk($sformatf("m44_f%0d_data%0d", f, i), wd(wb + i), exp44[i]);
      end
    end

    // Odd 5x3 map: last row and column must never be read.
    for (int i = 0; i < 15; i++) poke('h400 + i, 8'(i));
    wb = wr_addr.size();
    run(5, 3, 1, 'h400, 'h500, 0, cyc);
    chk("odd_latency", cyc, 32);
    chk("odd_nwrites", wr_addr.size() - wb, 2);
    chk("odd_addr0", wa(wb), 'h500);
    chk("odd_data0", wd(wb), 4);
    chk("odd_addr1", wa(wb + 1), 'h501);
    chk("odd_data1", wd(wb + 1), 10);
    sum_bad = rd_hits['h402] + rd_hits['h405] + rd_hits['h408] + rd_hits['h40B]
            + rd_hits['h40C] + rd_hits['h40D] + rd_hits['h40E];
    sum_all = 0;
    for (int i = 0; i < 15; i++) sum_all += rd_hits['h400 + i];
    chk("odd_dropped_reads", sum_bad, 0);
    chk("odd_total_reads", sum_all, 8);

    // Degenerate sizes finish without touching the BRAM.
    eb = en_cnt;
    run(4, 4, 0, 'h000, 'h600, 0, cyc);
    chk("c0_latency", cyc, 2);
    chk("c0_no_ena", en_cnt - eb, 0);
    eb = en_cnt;
    run(1, 4, 1, 'h000, 'h600, 0, cyc);
    chk("h1_latency", cyc, 2);
    chk("h1_no_ena", en_cnt - eb, 0);

    // Asynchronous reset mid-read, then a fresh run.
    height = 8'd4;
    width = 8'd4;
    channels = 10'd2;
    in_base_addr = '0;
    out_base_addr = ADDR_W'('h700);
    @(negedge clk);
    wb = wr_addr.size();
    pool_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_rst_ena", bram.ena, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ena", bram.ena, 0);
    chk("async_rst_wea", bram.wea, 0);
    chk("async_rst_finish", pool_finish, 0);
    chk("async_rst_addra", bram.addra, 0);
    @(negedge clk);
    pool_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_writes_so_far", wr_addr.size() - wb, 1);
    poke(12'h100, tbl[0].a0);
    poke(12'h101, tbl[0].a1);
    poke(12'h102, tbl[0].a2);
    poke(12'h103, tbl[0].a3);
    wb = wr_addr.size();
    run(2, 2, 1, 'h100, 'h200, 0, cyc);
    chk("post_rst_latency", cyc, 17);
    chk("post_rst_nwrites", wr_addr.size() - wb, 1);
    chk("post_rst_data", wd(wb), wexp(8'h09));

    chk("wea_without_ena", bad_wea, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool_flatten.md
Name: maxpool_flatten

Overview:
- Pooling stage directly upstream of the fully-connected engine.
- Reads a channel-major 8-bit feature map from the shared single-port VGG16 BRAM and applies 2x2, stride-2 max pooling.
- Writes the pooled values back to the same BRAM as one contiguous flattened vector. The FC stage consumes this vector from its data base address.
- One BRAM master at a time; the top-level sequencer enables this block, waits for pool_finish, then enables fc.

Parameters:
- DATA_W, 8, element width; signed two's complement.
- ADDR_W, 20, BRAM address width.
- READ_LAT, 2, clock edges between the edge that registers addra and the edge that samples douta.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- pool_en  input  1  level enable; starts the operation, and holding it low freezes the block.
- in_base_addr  input  ADDR_W  base address of the input feature map.
- out_base_addr  input  ADDR_W  base address of the flattened output (normally equal to the fc data base address).
- height  input  8  input rows H.
- width  input  8  input columns W.
- channels  input  10  channel count C.
- vgg16_bram_douta  input  DATA_W  BRAM read data.
- vgg16_bram_ena  output  1  BRAM enable.
- vgg16_bram_wea  output  1  BRAM write enable.
- vgg16_bram_addra  output  ADDR_W  BRAM address.
- vgg16_bram_dina  output  DATA_W  BRAM write data.
- pool_finish  output  1  done flag; held until pool_en drops.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE; ena, wea, addra, dina and pool_finish all 0; counters cleared.
- Reset mid-operation aborts immediately, with no partial write completed.
- pool_en low in any state: all registers hold (freeze). Exception: S_DONE, where pool_en low moves the FSM to S_IDLE.
- Input addressing: in_base + c*H*W + r*W + col.
- Output geometry: Ho = H>>1, Wo = W>>1. An odd last row or column is dropped.
- Output addressing: out_base + c*Ho*Wo + orow*Wo + ocol. Iteration order is ocol fastest, then orow, then c.
- Address arithmetic is done at ADDR_W bits; overflow wraps silently.
- States:
  - S_IDLE: latch sizes, clear counters and pool_finish; go to S_CHECK.
  - S_CHECK: if Ho==0, Wo==0, C==0 or c==C, go to S_DONE; else clear the window index k and go to S_READ.
  - S_READ: window element k=0..3 at (2orow+k[1], 2ocol+k[0]).
    - Each element costs READ_LAT+1 cycles: one address-issue cycle with ena=1, then READ_LAT wait cycles.
    - douta is sampled on the final cycle. k=0 loads max directly; k>0 takes the signed max.
    - ena is deasserted after k=3; go to S_WRITE.
  - S_WRITE:
    - Cycle 1: ena=1, wea=1, addra=output address, dina=max.
    - Cycle 2: ena=0, wea=0; advance ocol/orow/c with wrap (ocol==Wo-1 → 0 and orow++; orow==Ho-1 → 0 and c++); go to S_CHECK.
  - S_DONE: pool_finish=1, ena=wea=0; stay until pool_en=0, then go to S_IDLE (pool_finish clears there).
- Latency: per output, 1 + 4*(READ_LAT+1) + 2 cycles (15 at default).
- Total latency: 1 + N*15 + 1 cycles from the first S_IDLE cycle with pool_en=1 to pool_finish=1, where N = C*Ho*Wo.
- Comparison is signed; equal values keep the earlier one (no observable difference).
- wea is never high while ena is low; exactly N writes per run.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: the value written is max(pooled,0), i.e. negative results are written as 0 (fused ReLU).
- Undefined: the pooled max is written unchanged, including negatives.

Decomposition:
- Shared package vgg16_pkg holds:
  - DATA_W and ADDR_W constants.
  - The BRAM read-latency constant.
  - The one-hot state encoding type shared with the other layer FSMs.
- One natural sub-module: pool_addr_gen, which holds the c/orow/ocol/k counters and produces the input/output addresses and the last-element flags.
- The FSM and max register stay in the top.

Test Plan:
- H=W=2, C=1, inputs {3,-7,9,1} at in_base=0x100, out_base=0x200 → single write to 0x200 of 9; pool_finish high 17 cycles after pool_en.
- H=W=4, C=2, values = address index → 8 writes in order at out_base..out_base+7; each value is the bottom-right element of its window; no other BRAM writes.
- H=5, W=3, C=1 → Ho=2, Wo=1; 2 writes; last row and column never read (monitor addra).
- Window {-5,-2,-9,-3}: → -2 written (0xFE) without POOL_RELU_EN; → 0 written with it.
- C=0, or H=1 → no ena activity; pool_finish asserted 2 cycles after pool_en.
- Drop pool_en mid-S_READ for 5 cycles → outputs frozen, same final results. Then assert rst=0 mid-run → ena/wea/pool_finish are 0 immediately (asynchronous); a fresh run completes correctly.
